// File: rtl/mem_miss_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache fills and
// D-cache fills/single-word writes; returns fill words to the winning cache.
module mem_miss_arbiter #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic             mem_rvalid,
    input  logic [15:0]      mem_rdata,
    output logic             fill_valid,
    output logic             fill_to_d,
    output logic [IDX_W-1:0] fill_idx,
    output logic [15:0]      fill_data,
    output logic             i_done,
    output logic             d_done
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
    // Clears the byte offset within a block (word index plus byte-in-word bit).
    localparam logic [15:0] BASE_MASK = ~16'((32'd1 << (IDX_W + 1)) - 32'd1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic             owner, owner_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] iss_cnt, iss_nxt;
    logic [CNT_W-1:0] rcv_cnt, rcv_nxt;
    logic [15:0]      base, base_nxt;
    logic             gnt_d;
    logic             gnt_i;

    // Round robin: on a tie the side opposite to the last winner gets the port.
    assign gnt_d = d_req & (~i_req | ~last);
    assign gnt_i = i_req & ~gnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= 1'b0;
            last    <= 1'b0;
            iss_cnt <= '0;
            rcv_cnt <= '0;
            base    <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
            iss_cnt <= iss_nxt;
            rcv_cnt <= rcv_nxt;
            base    <= base_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        last_nxt   = last;
        iss_nxt    = iss_cnt;
        rcv_nxt    = rcv_cnt;
        base_nxt   = base;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        fill_valid = 1'b0;
        fill_to_d  = 1'b0;
        fill_idx   = '0;
        fill_data  = 16'h0000;
        i_done     = 1'b0;
        d_done     = 1'b0;

        case (state)
            S_IDLE: begin
                iss_nxt = '0;
                rcv_nxt = '0;
                if (gnt_d) begin
                    owner_nxt = 1'b1;
                    last_nxt  = 1'b1;
                    base_nxt  = d_we ? d_addr : (d_addr & BASE_MASK);
                    state_nxt = d_we ? S_WRITE : S_FILL;
                end else if (gnt_i) begin
                    owner_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    base_nxt  = i_addr & BASE_MASK;
                    state_nxt = S_FILL;
                end
            end

            S_FILL: begin
                if (iss_cnt < CNT_FULL) begin
                    mem_en   = 1'b1;
                    mem_addr = base + (16'(iss_cnt) << 1);
                    iss_nxt  = iss_cnt + CNT_W'(1);
                end
                // Read data returns in issue order, so the receive count is the word index.
                if (mem_rvalid) begin
                    fill_valid = 1'b1;
                    fill_to_d  = owner;
                    fill_idx   = rcv_cnt[IDX_W-1:0];
                    fill_data  = mem_rdata;
                    if (rcv_cnt == CNT_LAST) begin
                        i_done    = ~owner;
                        d_done    = owner;
                        iss_nxt   = '0;
                        rcv_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        rcv_nxt = rcv_cnt + CNT_W'(1);
                    end
                end
            end

            S_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_done    = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
